// File: rtl/run_sequencer.sv
// Program loader and run controller: streams a program into instruction memory, pulses the
// processor start, then watches for completion or a cycle-limit abort.
module run_sequencer #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000,
  parameter int unsigned START_PULSE    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [8:0]  ld_data,
  input  logic        ld_last,
  output logic        im_we,
  output logic [7:0]  im_addr,
  output logic [8:0]  im_wdata,
  output logic        core_start,
  input  logic        core_done,
  output logic        busy,
  output logic        finished,
  output logic        timeout,
  output logic [15:0] cycle_count,
  output logic [8:0]  word_count
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StLoad    = 3'd1;
  localparam logic [2:0] StStart   = 3'd2;
  localparam logic [2:0] StRun     = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;
  localparam logic [2:0] StTimeout = 3'd5;

  localparam logic [3:0] PulseLast = 4'(START_PULSE - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [8:0]  wc_q, wc_d;
  logic [15:0] cyc_q, cyc_d;
  logic        fin_q, fin_d;
  logic        to_q, to_d;
  logic [3:0]  pulse_q, pulse_d;

  logic        accept;
  logic [15:0] cyc_inc;

  assign accept  = ld_valid && (state_q == StLoad);
  assign cyc_inc = cyc_q + 16'd1;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wc_d    = wc_q;
    cyc_d   = cyc_q;
    fin_d   = fin_q;
    to_d    = to_q;
    pulse_d = pulse_q;
    case (state_q)
      StIdle, StDone, StTimeout: begin
        if (go) begin
          state_d = StLoad;
          addr_d  = 8'd0;
          wc_d    = 9'd0;
          cyc_d   = 16'd0;
          fin_d   = 1'b0;
          to_d    = 1'b0;
        end
      end
      StLoad: begin
        if (accept) begin
          wc_d   = wc_q + 9'd1;
          addr_d = addr_q + 8'd1;
          // Address 255 is the last slot, so the 256th word ends loading like ld_last.
          if (ld_last || (addr_q == 8'hFF)) begin
            state_d = StStart;
            addr_d  = 8'd0;
            pulse_d = 4'd0;
          end
        end
      end
      StStart: begin
        if (pulse_q == PulseLast) begin
          state_d = StRun;
        end else begin
          pulse_d = pulse_q + 4'd1;
        end
      end
      StRun: begin
        // Completion beats the cycle limit when both land on the same cycle.
        if (core_done) begin
          state_d = StDone;
          fin_d   = 1'b1;
        end else begin
          cyc_d = cyc_inc;
          if (cyc_inc == TIMEOUT_CYCLES) begin
            state_d = StTimeout;
            to_d    = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      addr_q  <= 8'd0;
      wc_q    <= 9'd0;
      cyc_q   <= 16'd0;
      fin_q   <= 1'b0;
      to_q    <= 1'b0;
      pulse_q <= 4'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wc_q    <= wc_d;
      cyc_q   <= cyc_d;
      fin_q   <= fin_d;
      to_q    <= to_d;
      pulse_q <= pulse_d;
    end
  end

  assign ld_ready    = (state_q == StLoad);
  assign im_we       = accept;
  assign im_addr     = addr_q;
  assign im_wdata    = ld_data;
  assign core_start  = (state_q == StStart);
  assign busy        = (state_q == StLoad) || (state_q == StStart) || (state_q == StRun);
  assign finished    = fin_q;
  assign timeout     = to_q;
  assign cycle_count = cyc_q;
  assign word_count  = wc_q;

endmodule
